// File: rtl/arb_mux_pkg.sv
// Shared constants for the arb_mux arbitrating multiplexer and its arbiter.
package arb_mux_pkg;

   localparam int unsigned ARB_RR    = 0;
   localparam int unsigned ARB_FIXED = 1;

   localparam int unsigned       STAT_W   = 16;
   localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

   // Channel-index width; kept at one bit so a single-channel build still has an index.
   function automatic int unsigned ch_width(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: round-robin search from ptr, or fixed lowest-index priority.
module rr_arbiter
   import arb_mux_pkg::*;
#(
   parameter int unsigned  NUM_CH   = 4,
   parameter int unsigned  ARB_MODE = ARB_RR,
   localparam int unsigned CH_W     = ch_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_idx
);

   localparam int unsigned SW = CH_W + 1;

   logic [SW-1:0]   sum;
   logic [CH_W-1:0] idx;
   logic            found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (ARB_MODE == ARB_FIXED) begin
            sum = SW'(k);
         end else begin
            // One extra bit holds ptr+k; a single subtract wraps any NUM_CH, not just 2^n.
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(NUM_CH)) begin
               sum = sum - SW'(NUM_CH);
            end
         end
         idx = sum[CH_W-1:0];
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating valid/ready multiplexer with a one-entry registered output stage.
// Optional per-channel grant counters are enabled with `define ARB_MUX_STATS_EN.
module arb_mux
   import arb_mux_pkg::*;
#(
   parameter int unsigned  NUM_CH   = 4,
   parameter int unsigned  DATA_W   = 32,
   parameter int unsigned  ARB_MODE = ARB_RR,
   localparam int unsigned CH_W     = ch_width(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   input  logic                     out_ready
`ifdef ARB_MUX_STATS_EN
   ,
   input  logic                     stat_clr,
   output logic [NUM_CH*STAT_W-1:0] stat_cnt
`endif
);

   logic              load_en;
   logic              in_xfer;
   logic [NUM_CH-1:0] grant;
   logic [CH_W-1:0]   grant_idx;
   logic [DATA_W-1:0] sel_data;

   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [CH_W-1:0]   out_ch_q;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

   rr_arbiter #(
      .NUM_CH   (NUM_CH),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .req       (in_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign load_en = !out_valid_q || out_ready;
   // rst_n gating keeps every in_ready low while reset is held.
   assign in_ready = grant & {NUM_CH{load_en & rst_n}};
   assign in_xfer  = |(in_valid & in_ready);

   // Grant is one-hot or zero, so an AND-OR tree selects the winning channel.
   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         sel_data = sel_data | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (in_xfer) begin
         rr_ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (in_xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_ch_q    <= grant_idx;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

`ifdef ARB_MUX_STATS_EN
   for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
      logic [STAT_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else if (stat_clr) begin
            cnt_q <= '0;
         end else if (in_valid[i] && in_ready[i] && (cnt_q != STAT_MAX)) begin
            cnt_q <= cnt_q + STAT_W'(1);
         end
      end

      assign stat_cnt[i*STAT_W +: STAT_W] = cnt_q;
   end
`endif

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised successor to the 2:1 datapath mux: an N-channel arbitrating multiplexer with a valid/ready handshake on every channel and on the output.
- Selects one requesting channel per transfer, using round-robin or fixed-priority arbitration.
- Registers the selected beat in a one-entry output stage, together with the source channel index.
- Sits between multiple producers (e.g. fetch/load requesters) and a single shared consumer (memory port, writeback bus).

Parameters:
- NUM_CH, 4, number of input channels (>=1).
- DATA_W, 32, data width per channel.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- CH_W, max(1,$clog2(NUM_CH)), channel-index width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_CH  per-channel request.
- in_data  in  NUM_CH*DATA_W  flattened channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel accept.
- out_valid  out  1  output register holds a beat.
- out_data  out  DATA_W  registered selected data.
- out_ch  out  CH_W  index of the channel that produced out_data.
- out_ready  in  1  consumer accept.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=0; in_ready evaluates to 0 while reset is held.
- Reset mid-operation: a buffered beat is discarded, no transfer completes, and rr_ptr returns to 0.
- load_en = !out_valid | out_ready (the output register is empty or draining this cycle).
- Grant is combinational from in_valid and rr_ptr and is one-hot or zero.
  - Round-robin: first asserted in_valid searching from rr_ptr upward, wrapping at NUM_CH-1 -> 0. Wrap must be correct for non-power-of-2 NUM_CH.
  - Fixed priority: lowest asserted index.
- in_ready[i] = grant[i] & load_en. At most one in_ready is high per cycle.
- Input transfer: in_valid[i] & in_ready[i]. On the next edge out_data <= channel i data, out_ch <= i, out_valid <= 1.
- rr_ptr advances to (i+1) mod NUM_CH only on an input transfer. No transfer leaves rr_ptr unchanged. rr_ptr is unused in fixed mode.
- Output transfer: out_valid & out_ready.
  - With no simultaneous input transfer: out_valid <= 0.
  - With a simultaneous input transfer: register replaced, out_valid stays 1. Full throughput is 1 beat/cycle.
- Latency: 1 cycle from input transfer to out_valid.
- Backpressure: out_valid=1 & out_ready=0 -> all in_ready=0; out_data and out_ch are held stable.
- No in_valid asserted -> no grant; the register drains and out_valid falls.
- Sources must hold in_valid and in_data until accepted. The block does not check this.
- Starvation bound (round-robin, output always ready): a continuously valid channel is granted within NUM_CH transfers.
- NUM_CH=1: always grant ch0, out_ch=0; the block degenerates to a registered pipeline stage.

Optional Feature:
- Macro: ARB_MUX_STATS_EN.
- Defined:
  - Extra output port stat_cnt, NUM_CH*16 bits: per-channel grant counters, 16-bit, saturating at 16'hFFFF.
  - A counter increments on its channel's input transfer.
  - Extra input stat_clr (1 bit) synchronously zeroes all counters. If stat_clr coincides with a grant, clear wins.
  - Counters reset to 0 on rst_n.
- Undefined: neither port exists, and no counter logic is present.

Decomposition:
- Shared package/header arb_mux_pkg holds:
  - mode constants ARB_RR=0, ARB_FIXED=1
  - STAT_W=16
  - STAT_MAX=16'hFFFF
- Sub-module rr_arbiter: parameters NUM_CH and ARB_MODE; inputs req and ptr; output one-hot grant plus encoded grant index.
- The top level holds load_en, the output register, rr_ptr update, and the optional counters.

Test Plan (NUM_CH=4, DATA_W=32):
1. Reset then idle: after rst_n release with all in_valid=0 -> out_valid=0, out_data=0, in_ready=4'b0000 for 5 cycles.
2. Single channel: ch2 in_valid=1 with data 32'hAAAAAAAA, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=AAAAAAAA, out_ch=2.
3. Round-robin fairness: all four valid with data 32'h0000000i, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, one beat per cycle.
4. Backpressure: ch1 data 32'h55555555 captured, then out_ready=0 for 3 cycles with ch0/ch3 valid -> out_data held at 55555555, in_ready=0. On out_ready=1 -> next beat from ch3 (rr_ptr=2 after the ch1 grant), then ch0.
5. Fixed mode (ARB_MODE=1): ch1 and ch3 continuously valid -> every beat has out_ch=1; ch3 is never granted while ch1 is valid.
6. Async reset mid-flight: assert rst_n=0 between edges while out_valid=1 -> out_valid drops immediately. After release the first grant with all channels valid is ch0.
   - With ARB_MUX_STATS_EN defined: after scenario 3, stat_cnt reads 2 per channel; pulsing stat_clr zeroes all counters.
